// File: rtl/bp_be_pkg.sv
// ---------------------------------------------------------------------------
// bp_be_pkg
// Backend-wide types shared by the late-writeback path:
//   - bp_params_e       : processor configuration selector
//   - bp_be_wb_pkt_s    : register-file writeback packet
//   - bp_be_late_src_e  : which late source (memory / long-latency) was granted
//   - BP_BE_WB_PKT_WIDTH(vaddr) : flat width of a writeback packet
// ---------------------------------------------------------------------------
`ifndef BP_BE_WB_PKT_WIDTH_DEFINED
`define BP_BE_WB_PKT_WIDTH_DEFINED
// The packet layout does not depend on the virtual address width; the
// argument is kept so every caller uses the same macro signature.
`define BP_BE_WB_PKT_WIDTH(vaddr_width_mp) ($bits(bp_be_wb_pkt_s) + 0 * (vaddr_width_mp))
`endif

package bp_be_pkg;

    typedef enum logic [1:0] {
        e_bp_default_cfg = 2'd0,
        e_bp_sv48_cfg    = 2'd1
    } bp_params_e;

    localparam int reg_addr_width_gp = 5;
    localparam int dword_width_gp    = 64;
    localparam int fflags_width_gp   = 5;

    typedef struct packed {
        logic                         ird_w_v;
        logic                         frd_w_v;
        logic [reg_addr_width_gp-1:0] rd_addr;
        logic [dword_width_gp-1:0]    rd_data;
        logic                         fflags_w_v;
        logic [fflags_width_gp-1:0]   fflags;
    } bp_be_wb_pkt_s;

    typedef enum logic {
        e_late_src_mem  = 1'b0,
        e_late_src_long = 1'b1
    } bp_be_late_src_e;

    function automatic int bp_vaddr_width(bp_params_e cfg);
        int w;
        case (cfg)
            e_bp_sv48_cfg: w = 48;
            default:       w = 39;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/bp_be_late_wb_fifo.sv
// ---------------------------------------------------------------------------
// bp_be_late_wb_fifo
// Small in-order queue holding late writeback packets until the register
// file's late port accepts them.
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   enq_v_i/enq_pkt_i: write one packet at the write pointer (ignored if full)
//   ready_i          : consumer ready; dequeue = head valid & ready
//   full_o           : count == els_p
//   deq_o            : a dequeue happens at the next rising edge
//   head_v_o/head_pkt_o : queue head (packet forced to 0 while empty)
// ---------------------------------------------------------------------------
module bp_be_late_wb_fifo
    import bp_be_pkg::*;
#(
    parameter  int els_p        = 4,
    localparam int ptr_width_lp = $clog2(els_p),
    localparam int cnt_width_lp = ptr_width_lp + 1
)
(
    input  logic          clk_i,
    input  logic          reset_n_i,
    input  logic          enq_v_i,
    input  bp_be_wb_pkt_s enq_pkt_i,
    input  logic          ready_i,
    output logic          full_o,
    output logic          deq_o,
    output logic          head_v_o,
    output bp_be_wb_pkt_s head_pkt_o
);

    logic [ptr_width_lp-1:0] wptr_q, wptr_d;
    logic [ptr_width_lp-1:0] rptr_q, rptr_d;
    logic [cnt_width_lp-1:0] count_q, count_d;
    logic                    enq_ok;

    // Storage carries no reset; anything read from it is masked while empty.
    bp_be_wb_pkt_s mem_q [els_p];

    assign full_o     = (count_q == cnt_width_lp'(els_p));
    assign head_v_o   = (count_q != '0);
    assign deq_o      = head_v_o & ready_i;
    assign enq_ok     = enq_v_i & ~full_o;
    // Asynchronous read so a packet written on one edge is at the head on
    // the following cycle.
    assign head_pkt_o = head_v_o ? mem_q[rptr_q] : '0;

    always_comb begin
        wptr_d  = enq_ok ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = deq_o  ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q;
        case ({enq_ok, deq_o})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq_ok) begin
            mem_q[wptr_q] <= enq_pkt_i;
        end
    end

endmodule

// File: rtl/bp_be_late_wb_arbiter.sv
// ---------------------------------------------------------------------------
// bp_be_late_wb_arbiter
// Merges late writebacks from the memory pipe and the long-latency pipe into
// one queue feeding the register file's late write port, and emits a
// one-cycle scoreboard-clear pulse for each packet written back.
//   clk_i, reset_n_i            : clock, asynchronous active-low reset
//   mem_pkt_i/mem_v_i/mem_yumi_o   : memory-source packet, valid, consume
//   long_pkt_i/long_v_i/long_yumi_o: long-source packet, valid, consume
//   wb_pkt_o                    : queue head packet
//   late_iwb_v_o/late_fwb_v_o   : head valid for integer / FP register file
//   wb_ready_and_i              : late write port ready
//   clr_v_o/clr_rd_addr_o/clr_float_o : registered clear pulse for the
//                                 packet dequeued on the previous cycle
// ---------------------------------------------------------------------------
module bp_be_late_wb_arbiter
    import bp_be_pkg::*;
#(
    parameter  bp_params_e bp_params_p     = e_bp_default_cfg,
    parameter  int         fifo_els_p      = 4,
    localparam int         vaddr_width_p   = bp_vaddr_width(bp_params_p),
    localparam int         wb_pkt_width_lp = `BP_BE_WB_PKT_WIDTH(vaddr_width_p)
)
(
    input  logic                         clk_i,
    input  logic                         reset_n_i,

    input  logic [wb_pkt_width_lp-1:0]   mem_pkt_i,
    input  logic                         mem_v_i,
    output logic                         mem_yumi_o,

    input  logic [wb_pkt_width_lp-1:0]   long_pkt_i,
    input  logic                         long_v_i,
    output logic                         long_yumi_o,

    output logic [wb_pkt_width_lp-1:0]   wb_pkt_o,
    output logic                         late_iwb_v_o,
    output logic                         late_fwb_v_o,
    input  logic                         wb_ready_and_i,

    output logic                         clr_v_o,
    output logic [reg_addr_width_gp-1:0] clr_rd_addr_o,
    output logic                         clr_float_o
);

    bp_be_late_src_e              last_grant_q, last_grant_d;
    logic                         clr_v_q, clr_v_d;
    logic [reg_addr_width_gp-1:0] clr_rd_addr_q, clr_rd_addr_d;
    logic                         clr_float_q, clr_float_d;

    logic          fifo_full;
    logic          fifo_deq;
    logic          head_v;
    bp_be_wb_pkt_s head_pkt;
    bp_be_wb_pkt_s enq_pkt;
    logic          space;
    logic          grant_mem;
    logic          grant_long;

    // Grants look only at the valids and registered occupancy, never at the
    // consumer ready, so there is no combinational path ready -> yumi.
    // Gating with reset_n_i keeps both yumis low while reset is held even
    // though the flops are already cleared.
    assign space = ~fifo_full & reset_n_i;

    always_comb begin
        grant_mem    = 1'b0;
        grant_long   = 1'b0;
        last_grant_d = last_grant_q;
        enq_pkt      = bp_be_wb_pkt_s'(mem_pkt_i);
        if (space) begin
            // Round-robin: on contention the source not granted last wins.
            if (mem_v_i && (!long_v_i || (last_grant_q == e_late_src_long))) begin
                grant_mem = 1'b1;
            end else if (long_v_i) begin
                grant_long = 1'b1;
            end
        end
        if (grant_mem) begin
            last_grant_d = e_late_src_mem;
        end else if (grant_long) begin
            last_grant_d = e_late_src_long;
            enq_pkt      = bp_be_wb_pkt_s'(long_pkt_i);
        end
    end

    always_comb begin
        clr_v_d       = fifo_deq;
        clr_rd_addr_d = clr_rd_addr_q;
        clr_float_d   = clr_float_q;
        if (fifo_deq) begin
            clr_rd_addr_d = head_pkt.rd_addr;
            clr_float_d   = head_pkt.frd_w_v;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            last_grant_q  <= e_late_src_long;
            clr_v_q       <= 1'b0;
            clr_rd_addr_q <= '0;
            clr_float_q   <= 1'b0;
        end else begin
            last_grant_q  <= last_grant_d;
            clr_v_q       <= clr_v_d;
            clr_rd_addr_q <= clr_rd_addr_d;
            clr_float_q   <= clr_float_d;
        end
    end

    bp_be_late_wb_fifo #(
        .els_p (fifo_els_p)
    ) u_fifo (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .enq_v_i    (grant_mem | grant_long),
        .enq_pkt_i  (enq_pkt),
        .ready_i    (wb_ready_and_i),
        .full_o     (fifo_full),
        .deq_o      (fifo_deq),
        .head_v_o   (head_v),
        .head_pkt_o (head_pkt)
    );

    assign mem_yumi_o    = grant_mem;
    assign long_yumi_o   = grant_long;
    assign wb_pkt_o      = head_pkt;
    assign late_iwb_v_o  = head_v & ~head_pkt.frd_w_v;
    assign late_fwb_v_o  = head_v &  head_pkt.frd_w_v;
    assign clr_v_o       = clr_v_q;
    assign clr_rd_addr_o = clr_rd_addr_q;
    assign clr_float_o   = clr_float_q;

endmodule

// File: tb/tb_bp_be_late_wb_arbiter.sv
module tb_bp_be_late_wb_arbiter;
    import bp_be_pkg::*;

    localparam int N = 4;
    localparam int W = $bits(bp_be_wb_pkt_s);

    logic                         clk = 1'b0;
    logic                         reset_n;
    logic [W-1:0]                 mem_pkt, long_pkt, wb_pkt;
    logic                         mem_v, long_v, mem_yumi, long_yumi;
    logic                         iwb_v, fwb_v, ready;
    logic                         clr_v, clr_float;
    logic [reg_addr_width_gp-1:0] clr_addr;

    always #5 clk = ~clk;

    bp_be_late_wb_arbiter #(
        .fifo_els_p (N)
    ) dut (
        .clk_i          (clk),
        .reset_n_i      (reset_n),
        .mem_pkt_i      (mem_pkt),
        .mem_v_i        (mem_v),
        .mem_yumi_o     (mem_yumi),
        .long_pkt_i     (long_pkt),
        .long_v_i       (long_v),
        .long_yumi_o    (long_yumi),
        .wb_pkt_o       (wb_pkt),
        .late_iwb_v_o   (iwb_v),
        .late_fwb_v_o   (fwb_v),
        .wb_ready_and_i (ready),
        .clr_v_o        (clr_v),
        .clr_rd_addr_o  (clr_addr),
        .clr_float_o    (clr_float)
    );

    // Reference model: the queue of packets in grant order, the source that
    // won last, and the expected clear-port values.
    int                           total = 0;
    int                           bad   = 0;
    bp_be_wb_pkt_s                exp_q[$];
    bp_be_late_src_e              last_src;
    logic                         push_pend;
    bp_be_wb_pkt_s                push_pkt;
    logic                         deq_pend;
    logic                         chk_en;
    logic                         exp_clr_v;
    logic [reg_addr_width_gp-1:0] exp_clr_addr;
    logic                         exp_clr_f;
    int                           yumi_cnt;
    bp_be_wb_pkt_s                nil;

    function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endfunction

    function automatic bp_be_wb_pkt_s mk_pkt(int rd, bit fp);
        bp_be_wb_pkt_s p;
        p.ird_w_v    = ~fp;
        p.frd_w_v    = fp;
        p.rd_addr    = rd[4:0];
        p.rd_data    = {$urandom, $urandom};
        p.fflags_w_v = fp & 1'($urandom_range(0, 1));
        p.fflags     = 5'($urandom);
        return p;
    endfunction

    // One clock of stimulus: drive inputs just after the edge, then at the
    // falling edge predict the grant from the model and compare the yumis.
    task automatic step(bit mv, bp_be_wb_pkt_s mp, bit lv, bp_be_wb_pkt_s lp, bit rdy);
        bit gm, gl;
        @(posedge clk);
        if (push_pend) exp_q.push_back(push_pkt);
        push_pend = 1'b0;
        #1;
        mem_v    = mv;
        mem_pkt  = mp;
        long_v   = lv;
        long_pkt = lp;
        ready    = rdy;
        @(negedge clk);
        gm = 1'b0;
        gl = 1'b0;
        if (exp_q.size() < N) begin
            if (mv && lv) begin
                gm = (last_src == e_late_src_long);
                gl = !gm;
            end else begin
                gm = mv;
                gl = lv;
            end
        end
        check("mem_yumi", mem_yumi, gm);
        check("long_yumi", long_yumi, gl);
        if (mem_yumi) yumi_cnt++;
        if (gm || gl) begin
            push_pend = 1'b1;
            push_pkt  = gm ? mp : lp;
            last_src  = gm ? e_late_src_mem : e_late_src_long;
            $display("grant %s rd=%0d fp=%0b", gm ? "mem" : "long", push_pkt.rd_addr, push_pkt.frd_w_v);
        end
    endtask

    task automatic drain();
        repeat (N + 3) step(1'b0, nil, 1'b0, nil, 1'b1);
    endtask

    // Monitor: compares the head and clear ports to the model every cycle
    // and retires the model head whenever the DUT presents a packet with
    // ready high.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                bit            hv;
                bp_be_wb_pkt_s h;
                hv = (exp_q.size() != 0);
                h  = hv ? exp_q[0] : nil;
                check("iwb_v", iwb_v, hv & ~h.frd_w_v);
                check("fwb_v", fwb_v, hv & h.frd_w_v);
                if (hv) check("head_pkt", wb_pkt, h);
                check("clr_v", clr_v, exp_clr_v);
                check("clr_addr", clr_addr, exp_clr_addr);
                check("clr_float", clr_float, exp_clr_f);
                deq_pend = hv && ready;
                if (deq_pend) $display("writeback rd=%0d fp=%0b", h.rd_addr, h.frd_w_v);
            end
            @(posedge clk);
            exp_clr_v = deq_pend;
            if (deq_pend) begin
                exp_clr_addr = exp_q[0].rd_addr;
                exp_clr_f    = exp_q[0].frd_w_v;
                void'(exp_q.pop_front());
                deq_pend = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        int guard;
        bp_be_wb_pkt_s seq_pkts[10];

        nil          = '0;
        reset_n      = 1'b0;
        mem_v        = 1'b1;
        long_v       = 1'b1;
        mem_pkt      = '0;
        long_pkt     = '0;
        ready        = 1'b1;
        chk_en       = 1'b0;
        push_pend    = 1'b0;
        deq_pend     = 1'b0;
        last_src     = e_late_src_long;
        exp_clr_v    = 1'b0;
        exp_clr_addr = '0;
        exp_clr_f    = 1'b0;
        yumi_cnt     = 0;

        // Reset state with both sources requesting.
        #12;
        check("rst_mem_yumi", mem_yumi, 1'b0);
        check("rst_long_yumi", long_yumi, 1'b0);
        check("rst_iwb_v", iwb_v, 1'b0);
        check("rst_fwb_v", fwb_v, 1'b0);
        check("rst_clr_v", clr_v, 1'b0);
        check("rst_clr_addr", clr_addr, 0);
        check("rst_clr_float", clr_float, 1'b0);
        mem_v  = 1'b0;
        long_v = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1 chk_en = 1'b1;

        // Simultaneous sources: mem first, then long.
        seq_pkts[0] = mk_pkt(5, 1'b0);
        seq_pkts[1] = mk_pkt(9, 1'b0);
        step(1'b1, seq_pkts[0], 1'b1, seq_pkts[1], 1'b1);
        step(1'b0, nil, 1'b1, seq_pkts[1], 1'b1);
        drain();

        // Full queue, then steady state at full.
        yumi_cnt = 0;
        for (int k = 0; k < 6; k++) step(1'b1, mk_pkt(k, 1'b0), 1'b0, nil, 1'b0);
        check("full_yumi_count", yumi_cnt, 4);
        for (int k = 0; k < 6; k++) step(1'b1, mk_pkt(20 + k, 1'b0), 1'b0, nil, 1'b1);
        drain();

        // FP steering.
        step(1'b1, mk_pkt(12, 1'b1), 1'b0, nil, 1'b1);
        drain();

        // Pointer wrap: hold each packet until consumed, ready toggling.
        for (int k = 0; k < 10; k++) seq_pkts[k] = mk_pkt(k, 1'b0);
        i     = 0;
        guard = 0;
        while (i < 10 && guard < 100) begin
            step(1'b1, seq_pkts[i], 1'b0, nil, guard[0] == 1'b0);
            if (mem_yumi) i++;
            guard++;
        end
        check("wrap_all_granted", i, 10);
        drain();

        // Reset mid-operation with three packets queued.
        for (int k = 0; k < 3; k++) step(1'b1, mk_pkt(k, 1'b0), 1'b0, nil, 1'b0);
        chk_en = 1'b0;
        @(posedge clk);
        #1;
        check("pre_rst_iwb_v", iwb_v, 1'b1);
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_rst_mem_yumi", mem_yumi, 1'b0);
        check("mid_rst_long_yumi", long_yumi, 1'b0);
        check("mid_rst_iwb_v", iwb_v, 1'b0);
        check("mid_rst_fwb_v", fwb_v, 1'b0);
        check("mid_rst_clr_v", clr_v, 1'b0);
        mem_v  = 1'b0;
        long_v = 1'b0;
        exp_q.delete();
        push_pend    = 1'b0;
        deq_pend     = 1'b0;
        last_src     = e_late_src_long;
        exp_clr_v    = 1'b0;
        exp_clr_addr = '0;
        exp_clr_f    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1 chk_en = 1'b1;
        step(1'b1, mk_pkt(3, 1'b0), 1'b1, mk_pkt(7, 1'b1), 1'b1);
        step(1'b0, nil, 1'b1, mk_pkt(7, 1'b1), 1'b1);
        drain();

        // Randomized traffic.
        for (int k = 0; k < 300; k++) begin
            step(1'($urandom_range(0, 1)), mk_pkt($urandom_range(0, 31), 1'($urandom_range(0, 1))),
                 1'($urandom_range(0, 1)), mk_pkt($urandom_range(0, 31), 1'($urandom_range(0, 1))),
                 $urandom_range(0, 9) < 7);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
